fifo_writer_packer: RTL and testbench
=====================================

Name: fifo_writer_packer

Overview:
Transmit-side counterpart of the FIFO byte serializer. It accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words. It writes each word into a 32-bit FIFO under i_FIFO_full backpressure and stops after a programmed byte length. It sits between a byte-wide producer (e.g. the AHB-Lite slave's TX data path) and the TX word FIFO.

Parameters:
LEN_W, 6, width of the byte-length input and byte counter; max transfer is 2^LEN_W-1 bytes

Ports:
CLK  input  1  clock
RESETn  input  1  reset, synchronous, active-low
Write_Request  input  1  start pulse/level; sampled only in IDLE
i_TX_BUFFER_LENGTH  input  LEN_W  transfer length in bytes; latched at start
serial_input  input  8  byte data
serial_input_valid  input  1  byte valid
serial_input_ready  output  1  byte accepted when valid && ready
i_FIFO_full  input  1  FIFO full flag
o_FIFO_wr_en  output  1  FIFO write strobe
o_FIFO_din  output  32  FIFO write data
Pack_Counter  output  2  current byte lane (0..3)
o_busy  output  1  high in any state except IDLE
o_done  output  1  one-cycle pulse at end of transfer
o_word_count  output  LEN_W  words written in the current or last transfer

Behaviour:
- States: IDLE, PACK, WRITE, DONE.
- Reset (RESETn=0 at CLK edge):
  - State=IDLE; Pack_Counter, byte counter, word register and o_word_count cleared.
  - Outputs: serial_input_ready=0, o_FIFO_wr_en=0, o_FIFO_din=0, o_busy=0, o_done=0.
  - Reset mid-transfer drops any partial word; no FIFO write occurs.
- IDLE:
  - ready=0.
  - On Write_Request=1: latch length L, clear byte counter, Pack_Counter, word register and o_word_count.
  - If L==0 go to DONE, else go to PACK.
- PACK:
  - ready=1.
  - On accept, the byte goes into lane Pack_Counter (lane0=[7:0], lane1=[15:8], lane2=[23:16], lane3=[31:24]). Byte counter increments and Pack_Counter increments, wrapping 3->0.
  - If the accepted byte is in lane 3, or the byte counter reaches L, go to WRITE next cycle.
  - valid=0 means hold; no change.
- WRITE:
  - ready=0; o_FIFO_din = word register.
  - o_FIFO_wr_en = !i_FIFO_full (combinational); the word is held indefinitely while the FIFO is full.
  - On a cycle with wr_en=1:
    - o_word_count increments.
    - Word register and Pack_Counter are cleared.
    - If byte counter == L go to DONE, else go to PACK.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Partial final word: unfilled upper lanes are 0. Word count = ceil(L/4).
- Latency and throughput:
  - A byte accepted into lane 3 at edge N gives wr_en high in cycle N+1 if the FIFO is not full.
  - Steady-state throughput is 4 bytes per 5 cycles.
- Write_Request outside IDLE is ignored. Bytes presented while ready=0 are not consumed; the producer holds them.
- o_FIFO_wr_en is never high outside WRITE. Exactly one write per word; no writes beyond ceil(L/4).
- o_FIFO_din in states other than WRITE: the word register value (don't-care for the FIFO).
- Max L=63 gives 16 words, the last with 3 valid bytes.

Test Plan:
- L=6, bytes 0x11..0x16 streamed back-to-back, FIFO not full:
  - writes 0x14131211 then 0x00001615, then o_done pulse.
  - o_word_count=2; ready low during each WRITE cycle.
- L=4, bytes 0xA0..0xA3: single write 0xA3A2A1A0, one-cycle done, return to IDLE.
- L=0 with Write_Request: no wr_en, no ready; o_done one cycle later, o_word_count=0.
- L=8 with i_FIFO_full=1 for 5 cycles at the first WRITE:
  - wr_en stays 0 and din is held stable at 0x03020100 (bytes 0x00..0x07).
  - On release, one write occurs, then the second word 0x07060504.
- L=8, reset asserted after 5 bytes accepted:
  - only the first word is written; everything returns to reset values.
  - A new L=3 request then writes 0x00CCBBAA.
- Write_Request pulsed during PACK with a different length: ignored; original L is honoured. Valid gaps between bytes: word contents unchanged.

Source files
------------

// File: rtl/fifo_writer_packer.sv
// Packs a little-endian byte stream into 32-bit words for the TX word FIFO.
// Stops after a programmed byte length; the final word is zero-padded.
module fifo_writer_packer #(
  parameter int LEN_W = 6
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Write_Request,
  input  logic [LEN_W-1:0] i_TX_BUFFER_LENGTH,
  input  logic [7:0]       serial_input,
  input  logic             serial_input_valid,
  output logic             serial_input_ready,
  input  logic             i_FIFO_full,
  output logic             o_FIFO_wr_en,
  output logic [31:0]      o_FIFO_din,
  output logic [1:0]       Pack_Counter,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_word_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PACK  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] byte_cnt;
  logic [LEN_W-1:0] byte_cnt_nx;
  logic [31:0]      word_q;
  logic             accept;

  assign serial_input_ready = (state == PACK);
  assign accept       = serial_input_ready && serial_input_valid;
  assign o_FIFO_wr_en = (state == WRITE) && !i_FIFO_full;
  assign o_FIFO_din   = word_q;
  assign o_busy       = (state != IDLE);
  assign o_done       = (state == DONE);
  assign byte_cnt_nx  = byte_cnt + 1'b1;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state        <= IDLE;
      len_q        <= '0;
      byte_cnt     <= '0;
      word_q       <= '0;
      Pack_Counter <= '0;
      o_word_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Write_Request) begin
            len_q        <= i_TX_BUFFER_LENGTH;
            byte_cnt     <= '0;
            word_q       <= '0;
            Pack_Counter <= '0;
            o_word_count <= '0;
            state <= (i_TX_BUFFER_LENGTH == '0) ? DONE : PACK;
          end
        end
        PACK: begin
          if (accept) begin
            word_q[Pack_Counter*8 +: 8] <= serial_input;
            byte_cnt     <= byte_cnt_nx;
            Pack_Counter <= Pack_Counter + 2'd1;
            if (Pack_Counter == 2'd3 || byte_cnt_nx == len_q)
              state <= WRITE;
          end
        end
        WRITE: begin
          if (o_FIFO_wr_en) begin
            o_word_count <= o_word_count + 1'b1;
            word_q       <= '0;
            Pack_Counter <= '0;
            state <= (byte_cnt == len_q) ? DONE : PACK;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_writer_packer.sv
// Directed bench for fifo_writer_packer.
// Captures FIFO writes at the falling edge and compares to hand-computed words.
module tb_fifo_writer_packer;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        Write_Request;
  logic [5:0]  i_TX_BUFFER_LENGTH;
  logic [7:0]  serial_input;
  logic        serial_input_valid;
  logic        serial_input_ready;
  logic        i_FIFO_full;
  logic        o_FIFO_wr_en;
  logic [31:0] o_FIFO_din;
  logic [1:0]  Pack_Counter;
  logic        o_busy;
  logic        o_done;
  logic [5:0]  o_word_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] wq[$];

  fifo_writer_packer #(.LEN_W(6)) dut (
    .CLK(CLK),
    .RESETn(RESETn),
    .Write_Request(Write_Request),
    .i_TX_BUFFER_LENGTH(i_TX_BUFFER_LENGTH),
    .serial_input(serial_input),
    .serial_input_valid(serial_input_valid),
    .serial_input_ready(serial_input_ready),
    .i_FIFO_full(i_FIFO_full),
    .o_FIFO_wr_en(o_FIFO_wr_en),
    .o_FIFO_din(o_FIFO_din),
    .Pack_Counter(Pack_Counter),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_word_count(o_word_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitor: a write is committed at the posedge following this sample
  always @(negedge CLK) begin
    if (o_FIFO_wr_en === 1'b1 && RESETn === 1'b1) begin
      wq.push_back(o_FIFO_din);
      chk("rdy_in_wr", {31'd0, serial_input_ready}, 32'd0);
    end
  end

  task automatic start(input logic [5:0] len);
    Write_Request = 1'b1;
    i_TX_BUFFER_LENGTH = len;
    @(negedge CLK);
    Write_Request = 1'b0;
    i_TX_BUFFER_LENGTH = 6'd0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    serial_input = b;
    serial_input_valid = 1'b1;
    while (!serial_input_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(negedge CLK);
    serial_input_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!o_done && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, {31'd0, o_done}, 32'd1);
    @(negedge CLK);
    chk({tag, "_1cyc"}, {30'd0, o_done, o_busy}, 32'd0);
  endtask

  initial begin
    RESETn = 1'b0;
    Write_Request = 1'b0;
    i_TX_BUFFER_LENGTH = 6'd0;
    serial_input = 8'd0;
    serial_input_valid = 1'b0;
    i_FIFO_full = 1'b0;
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_ctl", {29'd0, serial_input_ready, o_FIFO_wr_en, o_done}, 32'd0);
    chk("rst_din", o_FIFO_din, 32'd0);
    chk("rst_wc", {26'd0, o_word_count}, 32'd0);
    chk("rst_pc", {30'd0, Pack_Counter}, 32'd0);

    // L=6, back-to-back
    wq.delete();
    start(6'd6);
    for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i));
    wait_done("t6_done");
    chk("t6_n", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      chk("t6_w0", wq[0], 32'h14131211);
      chk("t6_w1", wq[1], 32'h00001615);
    end
    chk("t6_wc", {26'd0, o_word_count}, 32'd2);

    // L=4, single word
    wq.delete();
    start(6'd4);
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
    wait_done("t4_done");
    chk("t4_n", wq.size(), 32'd1);
    if (wq.size() == 1) chk("t4_w0", wq[0], 32'hA3A2A1A0);
    chk("t4_wc", {26'd0, o_word_count}, 32'd1);

    // L=0
    wq.delete();
    start(6'd0);
    chk("t0_done", {31'd0, o_done}, 32'd1);
    chk("t0_rdy", {31'd0, serial_input_ready}, 32'd0);
    @(negedge CLK);
    chk("t0_1cyc", {31'd0, o_done}, 32'd0);
    chk("t0_n", wq.size(), 32'd0);
    chk("t0_wc", {26'd0, o_word_count}, 32'd0);

    // L=8 with FIFO full at first WRITE
    wq.delete();
    i_FIFO_full = 1'b1;
    start(6'd8);
    for (int i = 0; i < 4; i++) send_byte(8'(i));
    for (int i = 0; i < 5; i++) begin
      chk("full_wr", {31'd0, o_FIFO_wr_en}, 32'd0);
      chk("full_din", o_FIFO_din, 32'h03020100);
      @(negedge CLK);
    end
    i_FIFO_full = 1'b0;
    for (int i = 4; i < 8; i++) send_byte(8'(i));
    wait_done("full_done");
    chk("full_n", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      chk("full_w0", wq[0], 32'h03020100);
      chk("full_w1", wq[1], 32'h07060504);
    end

    // Reset mid-transfer after 5 bytes
    wq.delete();
    start(6'd8);
    for (int i = 0; i < 5; i++) send_byte(8'h21 + 8'(i));
    RESETn = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    chk("mr_n", wq.size(), 32'd1);
    if (wq.size() == 1) chk("mr_w0", wq[0], 32'h24232221);
    chk("mr_busy", {31'd0, o_busy}, 32'd0);
    chk("mr_din", o_FIFO_din, 32'd0);
    chk("mr_wc", {26'd0, o_word_count}, 32'd0);
    chk("mr_pc", {30'd0, Pack_Counter}, 32'd0);
    repeat (3) @(negedge CLK);
    chk("mr_idle_n", wq.size(), 32'd1);
    wq.delete();
    start(6'd3);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    wait_done("l3_done");
    chk("l3_n", wq.size(), 32'd1);
    if (wq.size() == 1) chk("l3_w0", wq[0], 32'h00CCBBAA);

    // Request during PACK ignored, valid gaps
    wq.delete();
    start(6'd5);
    send_byte(8'h31);
    chk("ig_pc", {30'd0, Pack_Counter}, 32'd1);
    Write_Request = 1'b1;
    i_TX_BUFFER_LENGTH = 6'd2;
    @(negedge CLK);
    Write_Request = 1'b0;
    for (int i = 1; i < 5; i++) begin
      repeat (2) @(negedge CLK);
      send_byte(8'h31 + 8'(i));
    end
    wait_done("ig_done");
    chk("ig_n", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      chk("ig_w0", wq[0], 32'h34333231);
      chk("ig_w1", wq[1], 32'h00000035);
    end
    chk("ig_wc", {26'd0, o_word_count}, 32'd2);

    // Max length 63
    wq.delete();
    start(6'd63);
    for (int i = 0; i < 63; i++) send_byte(8'(i));
    wait_done("max_done");
    chk("max_n", wq.size(), 32'd16);
    if (wq.size() == 16) begin
      chk("max_w0", wq[0], 32'h03020100);
      chk("max_w15", wq[15], 32'h003E3D3C);
    end
    chk("max_wc", {26'd0, o_word_count}, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
